// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FIFO, overrun/timeout tracking and irq
// Optional: UART_RX_CTRL_ERRDROP_EN drops framing-error bytes and counts them.
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          rx_ferr_i,
  input  logic          rx_perr_i,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          pop_i,
  input  logic [AW:0]   thresh_i,
  input  logic [15:0]   to_cycles_i,
  input  logic          clr_ovr_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_ferr_o,
  output logic          rd_perr_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overrun_o,
  output logic          timeout_o,
  output logic [7:0]    ferr_cnt_o,
  output logic          irq_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overrun_q, overrun_d, timeout_q, timeout_d;
  logic [15:0]   to_cnt_q, to_cnt_d;
  logic [7:0]    ferr_cnt_q, ferr_cnt_d;
  logic          empty, full, push_req, ferr_hit, pop_ok, push_ok, ovr_set;
  logic [9:0]    head;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == FULL_LVL);
`ifdef UART_RX_CTRL_ERRDROP_EN
    ferr_hit = rx_valid_i & en_i & rx_ferr_i;
    push_req = rx_valid_i & en_i & ~rx_ferr_i;
`else
    ferr_hit = 1'b0;
    push_req = rx_valid_i & en_i;
`endif
    pop_ok  = pop_i & ~empty & ~flush_i;
    push_ok = push_req & ~flush_i & (~full | pop_ok);
    ovr_set = push_req & ~flush_i & full & ~pop_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
    end

    overrun_d = overrun_q;
    if (ovr_set)        overrun_d = 1'b1;
    else if (clr_ovr_i) overrun_d = 1'b0;

    // Idle counter only runs while data sits untouched in the FIFO.
    to_cnt_d = to_cnt_q;
    if (push_ok || pop_ok || flush_i || empty) to_cnt_d = '0;
    else if (to_cnt_q != 16'hFFFF)             to_cnt_d = to_cnt_q + 16'd1;

    timeout_d = timeout_q;
    if (flush_i || pop_ok || to_cycles_i == 16'd0)
      timeout_d = 1'b0;
    else if (!empty && !push_ok && to_cnt_q == to_cycles_i - 16'd1)
      timeout_d = 1'b1;

    ferr_cnt_d = ferr_cnt_q;
    if (ferr_hit && ferr_cnt_q != 8'hFF) ferr_cnt_d = ferr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      to_cnt_q   <= '0;
      ferr_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      to_cnt_q   <= to_cnt_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= {rx_perr_i, rx_ferr_i, rx_data_i};
  end

  // Storage is not reset, so the head is masked while nothing valid is held.
  assign head       = empty ? 10'd0 : mem_q[rd_ptr_q];
  assign rd_data_o  = head[7:0];
  assign rd_ferr_o  = head[8];
  assign rd_perr_o  = head[9];
  assign level_o    = level_q;
  assign empty_o    = empty;
  assign full_o     = full;
  assign overrun_o  = overrun_q;
  assign timeout_o  = timeout_q;
  assign ferr_cnt_o = ferr_cnt_q;
  assign irq_o      = ((thresh_i != '0) && (level_q >= thresh_i)) | timeout_q | overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with queue reference model
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i, rx_ferr_i, rx_perr_i, en_i, flush_i, pop_i, clr_ovr_i;
  logic [AW:0] thresh_i;
  logic [15:0] to_cycles_i;
  logic [7:0]  rd_data_o, ferr_cnt_o;
  logic        rd_ferr_o, rd_perr_o, empty_o, full_o, overrun_o, timeout_o, irq_o;
  logic [AW:0] level_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ferr_i(rx_ferr_i), .rx_perr_i(rx_perr_i), .en_i(en_i), .flush_i(flush_i),
    .pop_i(pop_i), .thresh_i(thresh_i), .to_cycles_i(to_cycles_i), .clr_ovr_i(clr_ovr_i),
    .rd_data_o(rd_data_o), .rd_ferr_o(rd_ferr_o), .rd_perr_o(rd_perr_o), .level_o(level_o),
    .empty_o(empty_o), .full_o(full_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
    .ferr_cnt_o(ferr_cnt_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; timeout measured as edges since last activity.
  logic [9:0]  mq [$];
  int unsigned ecnt = 0, last_evt = 0;
  bit          m_ovr = 0, m_tmo = 0, started = 0;
  int          m_fcnt = 0;

  always @(posedge clk) begin
    bit empty_b, req, pop, push;
    ecnt++;
    started = 1;
    if (rst) begin
      mq.delete();
      m_ovr = 0; m_tmo = 0; m_fcnt = 0; last_evt = ecnt;
    end else begin
      empty_b = (mq.size() == 0);
      req = rx_valid_i && en_i;
`ifdef UART_RX_CTRL_ERRDROP_EN
      if (req && rx_ferr_i) begin
        req = 0;
        if (m_fcnt < 255) m_fcnt++;
      end
`endif
      pop  = pop_i && !empty_b && !flush_i;
      push = req && !flush_i && (mq.size() < DEPTH || pop);
      if (req && !flush_i && mq.size() == DEPTH && !pop) m_ovr = 1;
      else if (clr_ovr_i) m_ovr = 0;
      if (flush_i || pop || to_cycles_i == 0) m_tmo = 0;
      else if (!empty_b && !push && (ecnt - last_evt) == to_cycles_i) m_tmo = 1;
      if (push || pop || flush_i || empty_b) last_evt = ecnt;
      if (flush_i) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({rx_perr_i, rx_ferr_i, rx_data_i});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("level", 32'(level_o), 32'(mq.size()));
      chk("empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
      chk("overrun", 32'(overrun_o), 32'(m_ovr));
      chk("timeout", 32'(timeout_o), 32'(m_tmo));
      chk("ferr_cnt", 32'(ferr_cnt_o), 32'(m_fcnt));
      chk("irq", 32'(irq_o),
          32'(((thresh_i != 0) && (mq.size() >= int'(thresh_i))) || m_tmo || m_ovr));
      chk("head", 32'({rd_perr_o, rd_ferr_o, rd_data_o}),
          32'((mq.size() > 0) ? mq[0] : 10'd0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rx_valid_i = 0; pop_i = 0; flush_i = 0; clr_ovr_i = 0; rx_ferr_i = 0; rx_perr_i = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] b, input logic f, input logic p);
    rx_data_i = b; rx_ferr_i = f; rx_perr_i = p; rx_valid_i = 1;
    step();
  endtask

  task automatic pop1();
    pop_i = 1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rx_data_i = 0; rx_valid_i = 0; rx_ferr_i = 0; rx_perr_i = 0; en_i = 1;
    flush_i = 0; pop_i = 0; clr_ovr_i = 0; thresh_i = 0; to_cycles_i = 0;
    idle(3);
    rst = 0;
    chk("reset_level", 32'(level_o), 0);
    chk("reset_empty", 32'(empty_o), 1);
    chk("reset_irq", 32'(irq_o), 0);
    chk("reset_rd_data", 32'(rd_data_o), 0);

    push(8'h41, 0, 0); push(8'h42, 0, 0); push(8'h43, 0, 0);
    chk("abc_level", 32'(level_o), 3);
    chk("abc_head0", 32'(rd_data_o), 32'h41);
    pop1(); chk("abc_head1", 32'(rd_data_o), 32'h42);
    pop1(); chk("abc_head2", 32'(rd_data_o), 32'h43);
    pop1(); chk("abc_empty", 32'(empty_o), 1);

    for (int i = 0; i < 16; i++) push(8'(i), 0, 0);
    chk("fill_full", 32'(full_o), 1);
    chk("fill_no_ovr", 32'(overrun_o), 0);
    push(8'h10, 0, 0);
    chk("ovr_set", 32'(overrun_o), 1);
    chk("ovr_irq", 32'(irq_o), 1);
    clr_ovr_i = 1; step();
    chk("ovr_clr", 32'(overrun_o), 0);
    chk("ovr_clr_irq", 32'(irq_o), 0);
    rx_data_i = 8'hAA; rx_valid_i = 1; pop_i = 1; step();
    chk("pp_full_level", 32'(level_o), 16);
    chk("pp_full_ovr", 32'(overrun_o), 0);
    chk("pp_full_head", 32'(rd_data_o), 32'h01);
    idle(0);
    for (int i = 0; i < 15; i++) pop1();
    chk("pp_tail", 32'(rd_data_o), 32'hAA);
    pop1();
    pop1();
    chk("pop_empty_level", 32'(level_o), 0);

    thresh_i = 4;
    push(8'h01, 0, 0); push(8'h02, 0, 0); push(8'h03, 0, 0);
    chk("thr_below", 32'(irq_o), 0);
    push(8'h04, 0, 0);
    chk("thr_hit", 32'(irq_o), 1);
    pop1();
    chk("thr_drop", 32'(irq_o), 0);
    flush_i = 1; step();
    thresh_i = 0;

    to_cycles_i = 100;
    push(8'h77, 0, 0);
    idle(99);
    chk("tmo_early", 32'(timeout_o), 0);
    idle(1);
    chk("tmo_fire", 32'(timeout_o), 1);
    pop1();
    chk("tmo_pop_clr", 32'(timeout_o), 0);
    push(8'h78, 0, 0);
    idle(100);
    chk("tmo_fire2", 32'(timeout_o), 1);
    flush_i = 1; step();
    chk("tmo_flush_clr", 32'(timeout_o), 0);
    to_cycles_i = 0;

    push(8'h55, 1, 0);
`ifdef UART_RX_CTRL_ERRDROP_EN
    chk("ferr_drop_level", 32'(level_o), 0);
    chk("ferr_drop_cnt", 32'(ferr_cnt_o), 1);
`else
    chk("ferr_keep_data", 32'(rd_data_o), 32'h55);
    chk("ferr_keep_flag", 32'(rd_ferr_o), 1);
`endif
    flush_i = 1; step();
    rx_data_i = 8'h66; rx_valid_i = 1; flush_i = 1; step();
    chk("flush_push_level", 32'(level_o), 0);

    for (int seg = 0; seg < 8; seg++) begin
      int pop_pct;
      thresh_i    = (AW+1)'($urandom_range(0, 18));
      to_cycles_i = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
      pop_pct     = (seg % 2) ? 15 : 50;
      for (int c = 0; c < 300; c++) begin
        en_i       = ($urandom_range(0, 9) != 0);
        rx_valid_i = ($urandom_range(0, 99) < 40);
        rx_data_i  = 8'($urandom);
        rx_ferr_i  = ($urandom_range(0, 9) == 0);
        rx_perr_i  = ($urandom_range(0, 9) == 0);
        pop_i      = ($urandom_range(0, 99) < pop_pct);
        flush_i    = ($urandom_range(0, 99) < 2);
        clr_ovr_i  = ($urandom_range(0, 99) < 5);
        step();
      end
      idle($urandom_range(0, 30));
    end

    rst = 1; step(); rst = 0;
    chk("final_reset_level", 32'(level_o), 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the oversampling UART receiver and the PLC register interface. Gates reception with an enable, buffers received bytes and their error flags in a first-word-fall-through FIFO, tracks overrun and character timeout, and raises a level interrupt toward the host CPU. All configuration comes from the register block as static inputs. The receiver itself is instantiated alongside, not inside, this block.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256
- AW, 4: log2(DEPTH)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data_i  in  8  byte from receiver
- rx_valid_i  in  1  one-cycle strobe, byte and flags valid
- rx_ferr_i  in  1  framing error for this byte
- rx_perr_i  in  1  parity error for this byte
- en_i  in  1  receive enable; 0 = incoming strobes ignored
- flush_i  in  1  one-cycle FIFO clear
- pop_i  in  1  one-cycle read strobe from host
- thresh_i  in  AW+1  interrupt fill threshold; 0 = threshold irq disabled
- to_cycles_i  in  16  idle timeout in clk cycles; 0 = timeout disabled
- clr_ovr_i  in  1  clears sticky overrun
- rd_data_o  out  8  head-of-FIFO byte
- rd_ferr_o  out  1  head-of-FIFO framing flag
- rd_perr_o  out  1  head-of-FIFO parity flag
- level_o  out  AW+1  entries held, 0..DEPTH
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- overrun_o  out  1  sticky: byte lost to full FIFO
- timeout_o  out  1  character-timeout flag
- ferr_cnt_o  out  8  saturating count of discarded framing-error bytes
- irq_o  out  1  combined interrupt

## Operation
- Storage: DEPTH x 10 bits {perr, ferr, data}; wr/rd pointers AW bits, wrap modulo DEPTH; level counter AW+1 bits.
- Push request = rx_valid_i & en_i (& ~rx_ferr_i when the drop feature is compiled in).
- Pop accepted only when level_o != 0; pop on empty is ignored with no state change.
- Priority, same cycle: flush > push/pop. Flush zeroes pointers and level, clears timeout_o, discards any concurrent push. Overrun, ferr_cnt_o are not cleared by flush.
- Push and pop together: both occur, level unchanged, legal when full or with level 1. When empty, pop ignored, push occurs.
- Push while full without pop: byte dropped, overrun_o <= 1. Overrun stays set until clr_ovr_i. If clr_ovr_i and a new overrun coincide, set wins.
- Timeout counter, 16 bits:
  - Cleared on any accepted push, accepted pop, flush, or while empty.
  - Otherwise increments, saturating.
  - When to_cycles_i != 0 and count == to_cycles_i - 1 while non-empty, timeout_o <= 1 next cycle.
  - timeout_o clears on accepted pop, flush, or when to_cycles_i == 0.
- irq_o = ((thresh_i != 0) & (level_o >= thresh_i)) | timeout_o | overrun_o.
- en_i deasserting does not alter FIFO contents; only new strobes are ignored.
- thresh_i greater than DEPTH: threshold term never fires.

## Timing
- Reset: pointers, level_o = 0, empty_o = 1, full_o = 0, overrun_o = 0, timeout_o = 0, ferr_cnt_o = 0, irq_o = 0. rd_data_o/rd_ferr_o/rd_perr_o read 0, because storage output is masked while empty.
- Reset mid-frame or mid-push discards all contents. No partial state survives.
- Push-to-visible latency: 1 cycle. Strobe at edge N gives rd_data_o, level_o, empty_o valid after edge N+1.
- FWFT: rd_data_o/flags are combinational from the head entry. The pop at edge N advances the head, with the next entry visible after edge N.
- level_o, empty_o, full_o, overrun_o, timeout_o are registered. irq_o is combinational from registered state.
- Timeout fires exactly to_cycles_i cycles after the last push/pop edge, with the FIFO non-empty throughout.

## Configuration
- UART_RX_CTRL_ERRDROP_EN defined:
  - Bytes with rx_ferr_i = 1 are never pushed and cannot cause overrun.
  - ferr_cnt_o increments per such byte while en_i = 1, saturating at 255.
  - Cleared only by reset.
- Undefined: framing-error bytes are pushed with the ferr flag set, and ferr_cnt_o is tied to 0.

## Test plan
- Push 0x41, 0x42, 0x43 with en_i = 1 and no pops -> level_o = 3. rd_data_o = 0x41, then 0x42, 0x43 after successive pops. empty_o = 1 after the third pop.
- DEPTH = 16: push 17 bytes (0x00..0x10) -> full_o = 1 after the 16th push, and overrun_o = 1 after the 17th. Pops return 0x00..0x0F. clr_ovr_i clears overrun_o and irq_o.
- Simultaneous push 0xAA and pop at full -> level stays 16, no overrun. Pop on empty -> level stays 0.
- thresh_i = 4, to_cycles_i = 0 -> irq_o rises one cycle after the 4th push and falls after the pop bringing level_o to 3.
- to_cycles_i = 100, push one byte, then idle -> timeout_o = 1 exactly 100 cycles after the push edge. A pop clears it. With no pops, flush clears it.
- Push with rx_ferr_i = 1, data 0x55:
  - With UART_RX_CTRL_ERRDROP_EN: level_o = 0 and ferr_cnt_o = 1.
  - Without it: rd_data_o = 0x55 and rd_ferr_o = 1.
  - Separately, a flush coinciding with a push leaves level_o = 0.
